tdc_multihit_combiner: RTL
==========================

Name: tdc_multihit_combiner

Overview:
- Parametrised successor of the single-shot TDC time combiner.
- Merges one start fine time, up to MAX_HITS stop fine times, and a coarse clk_i edge count into one absolute time word per stop hit.
- Adds an add/subtract stop mode, a coarse-count timeout, abort, and a valid/ready output with overrun detection.
- Sits between the TDC read sequencer (data_in/AluTriger) and the SDK/SD-card result path.

Parameters:
DATA_W, 28, width of TDC fine result data_in
TIME_W, 64, width of timedata
PRECISION, 40, ps per fine LSB
CLKTIME, 25000, ps per clk_i period
MAX_HITS, 4, stop hits accepted per start (1..15)
CNT_W, 32, coarse counter width
TIMEOUT_CNT, 40000, coarse count at which an armed measurement is aborted with timeout
SUB_STOP, 0, 0: result = F1+F2+C; 1: result = F1-F2+C, clamped at 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_i  in  1  TDC reference clock, async, rising edges counted
start  in  1  async measurement start level
stop  in  1  async stop-hit level
TDC_stop  in  1  TDC conversion-finished strobe, synchronous to clk
AluTriger  in  1  one-cycle strobe: data_in valid
data_in  in  DATA_W  TDC fine result
abort  in  1  one-cycle request to return to IDLE
out_ready  in  1  downstream accepts result
out_valid  out  1  result valid
timedata  out  TIME_W  combined time in ps
hit_idx  out  4  hit number of this result (0-based)
timeout  out  1  result is a timeout marker
overrun  out  1  sticky: result dropped due to backpressure; cleared by reset only
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, high): all outputs 0; state IDLE; counters, fine registers and synchronisers 0.
- start, stop, clk_i: 3-flop sync each; pulse = s2 & !s3 (one clk cycle per rising edge, 3-cycle latency).
- Fine capture: F = data_in*PRECISION, zero-extended to TIME_W, stored on the AluTriger cycle. Pending-start flag → F1; else pending-stop flag → F2. AluTriger with no pending flag is ignored.
- Coarse C = cnt*CLKTIME in TIME_W. cnt clears to 0 on entering WAIT_T1 and increments on each clk_i pulse while in ARMED or WAIT_T2. It is cumulative across hits and saturates at all-ones.
- Final arithmetic is computed in EMIT and registered. SUB_STOP=1 with a negative sum gives timedata = 0.
- State machine:
  - IDLE: start pulse → WAIT_T1; sets start-pending.
  - WAIT_T1: exits to ARMED when TDC_stop has been seen AND F1 captured, in either order or the same cycle.
  - ARMED: stop pulse → WAIT_T2; sets stop-pending. cnt >= TIMEOUT_CNT → EMIT with timeout=1.
  - WAIT_T2: exits to EMIT when TDC_stop seen AND F2 captured. A clk_i pulse on the same cycle as TDC_stop is counted.
  - EMIT (1 cycle): loads the output register. Goes to IDLE if timeout or hit_idx==MAX_HITS-1; else to ARMED with hit_idx+1.
- Abort in any non-IDLE state → IDLE next cycle. Clears pending flags and emits nothing. Abort wins over all other events.
- start pulse outside IDLE is ignored. stop pulse outside ARMED is ignored.
- Output handshake: EMIT with out_valid=0, or out_valid && out_ready on the same cycle, loads the register and sets out_valid=1 the next cycle.
- EMIT with out_valid && !out_ready: new result dropped, overrun set, held result unchanged.
- out_valid clears on out_ready when no new load occurs.
- Timeout result: timedata = C, hit_idx = current hit.
- Latency: last of (TDC_stop, AluTriger) for a hit → out_valid high 2 cycles later.

Test Plan:
- SUB_STOP=0, start; F1 data 100; 3 clk_i edges; stop; F2 data 200; out_ready=1 → timedata=4000+8000+75000=87000, hit_idx=0, timeout=0, busy low after.
- Same stimulus, SUB_STOP=1 → timedata=71000. Variant F1=0, F2=1000, cnt=0 → timedata=0 (clamp).
- MAX_HITS=4, four stops at cnt 2,5,9,12, F2=50 each, F1=0 → timedata 52000, 127000, 227000, 302000; hit_idx 0..3; then IDLE; fifth stop ignored.
- TIMEOUT_CNT=8, no stop, 8 clk_i edges → timedata=200000, timeout=1, state IDLE.
- out_ready=0 held across two hits → first result held unchanged, overrun=1; out_ready=1 → out_valid drops the cycle after.
- abort in WAIT_T2 and reset asserted mid-ARMED → no result emitted; all outputs 0 after reset; a fresh start measures correctly.

Source files
------------

// File: rtl/tdc_multihit_combiner.sv
// tdc_multihit_combiner: merges start/stop fine times and a coarse clk_i count into one absolute time per stop hit
module tdc_multihit_combiner #(
  parameter int DATA_W      = 28,
  parameter int TIME_W      = 64,
  parameter int PRECISION   = 40,
  parameter int CLKTIME     = 25000,
  parameter int MAX_HITS    = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CNT = 40000,
  parameter int SUB_STOP    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_i,
  input  logic              start,
  input  logic              stop,
  input  logic              TDC_stop,
  input  logic              AluTriger,
  input  logic [DATA_W-1:0] data_in,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [TIME_W-1:0] timedata,
  output logic [3:0]        hit_idx,
  output logic              timeout,
  output logic              overrun,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, WAIT_T1, ARMED, WAIT_T2, EMIT} state_t;
  state_t state_q, state_d;
  logic [2:0] start_s_q, start_s_d, stop_s_q, stop_s_d, clki_s_q, clki_s_d;
  logic start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;
  logic tdc_seen_q, tdc_seen_d, tmo_q, tmo_d;
  logic [TIME_W-1:0] f1_q, f1_d, f2_q, f2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] hit_q, hit_d;
  logic out_valid_q, out_valid_d, timeout_q, timeout_d, overrun_q, overrun_d;
  logic [TIME_W-1:0] timedata_q, timedata_d;
  logic [3:0] hit_idx_q, hit_idx_d;
  logic start_p, stop_p, clki_p, tdc_ok, emit, load;
  logic [TIME_W-1:0] fine, coarse, pos, result;
  assign start_p = start_s_q[1] & ~start_s_q[2];
  assign stop_p  = stop_s_q[1] & ~stop_s_q[2];
  assign clki_p  = clki_s_q[1] & ~clki_s_q[2];
  assign tdc_ok  = tdc_seen_q | TDC_stop;
  assign fine    = TIME_W'(data_in) * TIME_W'(PRECISION);
  assign coarse  = TIME_W'(cnt_q) * TIME_W'(CLKTIME);
  assign pos     = f1_q + coarse;
  assign result  = tmo_q ? coarse : (SUB_STOP != 0) ? ((pos < f2_q) ? '0 : pos - f2_q) : pos + f2_q;
  assign out_valid = out_valid_q;
  assign timedata  = timedata_q;
  assign hit_idx   = hit_idx_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;
  assign busy      = state_q != IDLE;
  // next-state: sync shift, fine capture, coarse count, sequencing, abort override and output handshake
  always_comb begin
    start_s_d = {start_s_q[1:0], start};
    stop_s_d = {stop_s_q[1:0], stop};
    clki_s_d = {clki_s_q[1:0], clk_i};
    state_d = state_q;
    start_pend_d = start_pend_q;
    stop_pend_d = stop_pend_q;
    tdc_seen_d = tdc_seen_q | TDC_stop;
    tmo_d = tmo_q;
    f1_d = f1_q;
    f2_d = f2_q;
    hit_d = hit_q;
    cnt_d = (clki_p && (state_q == ARMED || state_q == WAIT_T2) && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    if (AluTriger && start_pend_q) begin
      f1_d = fine;
      start_pend_d = 1'b0;
    end else if (AluTriger && stop_pend_q) begin
      f2_d = fine;
      stop_pend_d = 1'b0;
    end
    case (state_q)
      IDLE: if (start_p) begin
        state_d = WAIT_T1;
        start_pend_d = 1'b1;
        stop_pend_d = 1'b0;
        tdc_seen_d = 1'b0;
        tmo_d = 1'b0;
        cnt_d = '0;
        hit_d = '0;
      end
      WAIT_T1: if (tdc_ok && (!start_pend_q || AluTriger)) state_d = ARMED;
      ARMED: if (cnt_q >= CNT_W'(TIMEOUT_CNT)) begin
        state_d = EMIT;
        tmo_d = 1'b1;
      end else if (stop_p) begin
        state_d = WAIT_T2;
        stop_pend_d = 1'b1;
        tdc_seen_d = 1'b0;
      end
      WAIT_T2: if (tdc_ok && (!stop_pend_q || AluTriger)) state_d = EMIT;
      EMIT: if (tmo_q || hit_q == 4'(MAX_HITS - 1)) state_d = IDLE;
      else begin
        state_d = ARMED;
        hit_d = hit_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      start_pend_d = 1'b0;
      stop_pend_d = 1'b0;
    end
    emit = state_q == EMIT && !abort;
    load = emit && (!out_valid_q || out_ready);
    overrun_d = overrun_q | (emit & ~load);
    out_valid_d = load | (out_valid_q & ~out_ready);
    timedata_d = load ? result : timedata_q;
    hit_idx_d = load ? hit_q : hit_idx_q;
    timeout_d = load ? tmo_q : timeout_q;
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_s_q <= '0;
      stop_s_q <= '0;
      clki_s_q <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      tdc_seen_q <= 1'b0;
      tmo_q <= 1'b0;
      f1_q <= '0;
      f2_q <= '0;
      cnt_q <= '0;
      hit_q <= '0;
      out_valid_q <= 1'b0;
      timedata_q <= '0;
      hit_idx_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_s_q <= start_s_d;
      stop_s_q <= stop_s_d;
      clki_s_q <= clki_s_d;
      start_pend_q <= start_pend_d;
      stop_pend_q <= stop_pend_d;
      tdc_seen_q <= tdc_seen_d;
      tmo_q <= tmo_d;
      f1_q <= f1_d;
      f2_q <= f2_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      out_valid_q <= out_valid_d;
      timedata_q <= timedata_d;
      hit_idx_q <= hit_idx_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end
endmodule
